// File: rtl/universal_shift_reg_n_if.sv
// Bus bundle for universal_shift_reg_n: control/data inputs and register outputs.
// The master side drives the operation; the slave side is the shift register itself.
interface universal_shift_reg_n_if #(
    parameter int WIDTH = 8
);
    localparam int CNT_W = $clog2(WIDTH);

    logic             en;
    logic [2:0]       mode;
    logic             r_serialin;
    logic             l_serialin;
    logic [WIDTH-1:0] parallel_in;
    logic [WIDTH-1:0] q;
    logic             out;
    logic [CNT_W-1:0] shift_cnt;
    logic             frame_done;

    modport master (
        output en, mode, r_serialin, l_serialin, parallel_in,
        input  q, out, shift_cnt, frame_done
    );

    modport slave (
        input  en, mode, r_serialin, l_serialin, parallel_in,
        output q, out, shift_cnt, frame_done
    );
endinterface

// File: rtl/universal_shift_reg_n.sv
// Universal WIDTH-bit shift register with clock enable, registered shift-out bit
// and a frame counter that pulses frame_done after every WIDTH shift-class operations.
module universal_shift_reg_n #(
    parameter int WIDTH = 8
) (
    input  logic                      clk,
    input  logic                      rst,
    universal_shift_reg_n_if.slave    bus
);
    localparam int CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

    typedef enum logic [2:0] {
        MODE_HOLD = 3'b000,
        MODE_SHR  = 3'b001,
        MODE_SHL  = 3'b010,
        MODE_LOAD = 3'b011,
        MODE_ROR  = 3'b100,
        MODE_ROL  = 3'b101,
        MODE_ASR  = 3'b110,
        MODE_RSVD = 3'b111
    } mode_e;

    logic [WIDTH-1:0] data_q, data_d;
    logic             out_q, out_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             frame_done_q, frame_done_d;
    logic             shift_op;

    always_comb begin
        data_d       = data_q;
        out_d        = out_q;
        cnt_d        = cnt_q;
        frame_done_d = 1'b0;
        shift_op     = 1'b0;

        if (bus.en) begin
            case (mode_e'(bus.mode))
                MODE_SHR: begin
                    data_d   = {bus.r_serialin, data_q[WIDTH-1:1]};
                    out_d    = data_q[0];
                    shift_op = 1'b1;
                end
                MODE_SHL: begin
                    data_d   = {data_q[WIDTH-2:0], bus.l_serialin};
                    out_d    = data_q[WIDTH-1];
                    shift_op = 1'b1;
                end
                MODE_LOAD: begin
                    data_d = bus.parallel_in;
                    cnt_d  = '0;
                end
                MODE_ROR: begin
                    data_d   = {data_q[0], data_q[WIDTH-1:1]};
                    out_d    = data_q[0];
                    shift_op = 1'b1;
                end
                MODE_ROL: begin
                    data_d   = {data_q[WIDTH-2:0], data_q[WIDTH-1]};
                    out_d    = data_q[WIDTH-1];
                    shift_op = 1'b1;
                end
                MODE_ASR: begin
                    data_d   = {data_q[WIDTH-1], data_q[WIDTH-1:1]};
                    out_d    = data_q[0];
                    shift_op = 1'b1;
                end
                default: ; // hold and reserved leave everything as is
            endcase
        end

        // Every shift-class op advances the frame, regardless of direction.
        if (shift_op) begin
            if (cnt_q == LAST_CNT) begin
                cnt_d        = '0;
                frame_done_d = 1'b1;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data_q       <= '0;
            out_q        <= 1'b0;
            cnt_q        <= '0;
            frame_done_q <= 1'b0;
        end else begin
            data_q       <= data_d;
            out_q        <= out_d;
            cnt_q        <= cnt_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign bus.q          = data_q;
    assign bus.out        = out_q;
    assign bus.shift_cnt  = cnt_q;
    assign bus.frame_done = frame_done_q;
endmodule

// File: tb/tb_universal_shift_reg_n.sv
// Directed bench for universal_shift_reg_n (WIDTH=8): a behavioural model checked
// every falling edge, plus literal expectations from hand-worked vectors.
module tb_universal_shift_reg_n;
    localparam int W  = 8;
    localparam int CW = $clog2(W);

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   errors = 0;
    int   checks = 0;
    int   shifts_done;
    int   pulses;
    int   pulse_at [2];

    always #5 clk = ~clk;

    universal_shift_reg_n_if #(.WIDTH(W)) bus();

    universal_shift_reg_n #(.WIDTH(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Behavioural model: register value, last bit out, position within frame.
    logic [W-1:0] m_q;
    logic         m_out;
    int           m_pos;
    logic         m_fd;

    always @(posedge clk or posedge rst) begin : model
        automatic logic [W-1:0] nq   = m_q;
        automatic logic         nout = m_out;
        automatic int           npos = m_pos;
        automatic logic         nfd  = 1'b0;
        automatic bit           sh   = 1'b0;
        if (rst) begin
            m_q <= '0; m_out <= 1'b0; m_pos <= 0; m_fd <= 1'b0;
        end else begin
            if (bus.en) begin
                case (bus.mode)
                    3'd1: begin nout = m_q[0];   nq = (m_q >> 1) | (W'(bus.r_serialin) << (W-1)); sh = 1; end
                    3'd2: begin nout = m_q[W-1]; nq = (m_q << 1) | W'(bus.l_serialin); sh = 1; end
                    3'd3: begin nq = bus.parallel_in; npos = 0; end
                    3'd4: begin nout = m_q[0];   nq = (m_q >> 1) | (m_q << (W-1)); sh = 1; end
                    3'd5: begin nout = m_q[W-1]; nq = (m_q << 1) | (m_q >> (W-1)); sh = 1; end
                    3'd6: begin nout = m_q[0];   nq = W'($signed(m_q) >>> 1); sh = 1; end
                    default: ;
                endcase
            end
            if (sh) begin
                npos = (npos + 1) % W;
                nfd  = (npos == 0);
            end
            m_q <= nq; m_out <= nout; m_pos <= npos; m_fd <= nfd;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, required %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Single compare process: DUT outputs versus the model, every cycle.
    always @(negedge clk) begin
        chk("model_q",    32'(bus.q),          32'(m_q));
        chk("model_out",  32'(bus.out),        32'(m_out));
        chk("model_cnt",  32'(bus.shift_cnt),  32'(m_pos));
        chk("model_fd",   32'(bus.frame_done), 32'(m_fd));
    end

    task automatic step(input logic e, input logic [2:0] m, input logic rs, input logic ls,
                        input logic [W-1:0] pin);
        bus.en = e; bus.mode = m; bus.r_serialin = rs; bus.l_serialin = ls; bus.parallel_in = pin;
        @(posedge clk);
        #1;
        $display("step en=%0b mode=%0d rs=%0b ls=%0b pin=%02h -> q=%02h out=%0b cnt=%0d fd=%0b",
                 e, m, rs, ls, pin, bus.q, bus.out, bus.shift_cnt, bus.frame_done);
    endtask

    task automatic expect_state(input string tag, input logic [W-1:0] eq, input logic eo,
                                input int ec, input logic efd);
        chk({tag, "_q"},   32'(bus.q),          32'(eq));
        chk({tag, "_out"}, 32'(bus.out),        32'(eo));
        chk({tag, "_cnt"}, 32'(bus.shift_cnt),  32'(ec));
        chk({tag, "_fd"},  32'(bus.frame_done), 32'(efd));
    endtask

    logic [W-1:0] a5_bits;
    logic [W-1:0] ashr_exp [3];

    initial begin
        bus.en = 1'b0; bus.mode = 3'd0; bus.r_serialin = 1'b0; bus.l_serialin = 1'b0;
        bus.parallel_in = '0;
        a5_bits = 8'hA5;
        ashr_exp[0] = 8'hC8; ashr_exp[1] = 8'hE4; ashr_exp[2] = 8'hF2;

        #12;
        expect_state("reset_init", 8'h00, 1'b0, 0, 1'b0);
        rst = 1'b0;

        // Asynchronous reset mid-cycle after a load and some shifts.
        step(1, 3'd3, 0, 0, 8'hA5);
        step(1, 3'd1, 0, 0, 8'h00);
        step(1, 3'd1, 0, 0, 8'h00);
        #2 rst = 1'b1;
        #1 expect_state("async_rst", 8'h00, 1'b0, 0, 1'b0);
        step(1, 3'd3, 0, 0, 8'hFF);
        step(1, 3'd1, 1, 0, 8'h00);
        expect_state("rst_held", 8'h00, 1'b0, 0, 1'b0);
        #2 rst = 1'b0;

        // Load A5 and shift right eight times with ones entering.
        step(1, 3'd3, 0, 0, 8'hA5);
        expect_state("load_a5", 8'hA5, 1'b0, 0, 1'b0);
        for (int i = 0; i < W; i++) begin
            step(1, 3'd1, 1, 0, 8'h00);
            chk("shr_out_seq", 32'(bus.out), 32'(a5_bits[i]));
            chk("shr_fd", 32'(bus.frame_done), (i == W-1) ? 32'd1 : 32'd0);
        end
        expect_state("shr_final", 8'hFF, 1'b1, 0, 1'b1);
        step(1, 3'd0, 0, 0, 8'h00);
        chk("fd_one_cycle", 32'(bus.frame_done), 32'd0);

        // Rotate left then shift left.
        step(1, 3'd3, 0, 0, 8'h81);
        step(1, 3'd5, 0, 1, 8'h00);
        expect_state("rol", 8'h03, 1'b1, 1, 1'b0);
        step(1, 3'd2, 0, 0, 8'h00);
        expect_state("shl", 8'h06, 1'b0, 2, 1'b0);

        // Arithmetic shift right, r_serialin toggling.
        step(1, 3'd3, 0, 0, 8'h90);
        for (int i = 0; i < 3; i++) begin
            step(1, 3'd6, (i % 2 == 0), 0, 8'h00);
            chk("ashr_q", 32'(bus.q), 32'(ashr_exp[i]));
            chk("ashr_out", 32'(bus.out), 32'd0);
        end

        // Enable low, reserved mode and hold all freeze state.
        step(1, 3'd3, 0, 0, 8'h3C);
        step(1, 3'd1, 0, 0, 8'h00);
        step(1, 3'd1, 0, 0, 8'h00);
        expect_state("pre_hold", 8'h0F, 1'b0, 2, 1'b0);
        for (int i = 0; i < 5; i++) step(0, 3'd1, 1, 1, 8'hFF);
        expect_state("en_low", 8'h0F, 1'b0, 2, 1'b0);
        step(1, 3'd7, 1, 1, 8'hFF);
        expect_state("reserved", 8'h0F, 1'b0, 2, 1'b0);
        step(1, 3'd0, 1, 1, 8'hFF);
        expect_state("hold", 8'h0F, 1'b0, 2, 1'b0);

        // Load mid-frame discards the partial count.
        for (int i = 0; i < 5; i++) step(1, 3'd4, 0, 0, 8'h00);
        chk("cnt_5", 32'(bus.shift_cnt), 32'd7);
        step(1, 3'd3, 0, 0, 8'h55);
        chk("load_clears_cnt", 32'(bus.shift_cnt), 32'd0);
        for (int i = 0; i < W-1; i++) begin
            step(1, (i % 2 == 0) ? 3'd1 : 3'd2, 0, 1, 8'h00);
            chk("no_early_fd", 32'(bus.frame_done), 32'd0);
        end
        step(1, 3'd4, 0, 0, 8'h00);
        chk("fd_after_8", 32'(bus.frame_done), 32'd1);

        // Sixteen back-to-back shifts: exactly two pulses, after shifts 8 and 16.
        step(1, 3'd3, 0, 0, 8'hC3);
        pulses = 0; shifts_done = 0;
        pulse_at[0] = -1; pulse_at[1] = -1;
        for (int i = 0; i < 2*W; i++) begin
            step(1, 3'd5, 0, 0, 8'h00);
            shifts_done++;
            if (bus.frame_done) begin
                if (pulses < 2) pulse_at[pulses] = shifts_done;
                pulses++;
            end
        end
        chk("two_pulses", 32'(pulses), 32'd2);
        chk("pulse1_pos", 32'(pulse_at[0]), 32'd8);
        chk("pulse2_pos", 32'(pulse_at[1]), 32'd16);
        chk("rol16_q", 32'(bus.q), 32'hC3);
        step(0, 3'd0, 0, 0, 8'h00);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
